// File: rtl/amci_arbiter.sv
// Two-requester round-robin arbiter in front of a single-beat AXI master (AMCI).
// One transaction in flight at a time: IDLE -> ISSUE (start pulse) -> WAIT (downstream idle) -> IDLE.
module amci_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQA_VALID,
    input  logic                  REQA_RNW,
    input  logic [ADDR_WIDTH-1:0] REQA_ADDR,
    input  logic [DATA_WIDTH-1:0] REQA_WDATA,
    input  logic                  REQB_VALID,
    input  logic                  REQB_RNW,
    input  logic [ADDR_WIDTH-1:0] REQB_ADDR,
    input  logic [DATA_WIDTH-1:0] REQB_WDATA,
    output logic                  REQA_READY,
    output logic                  REQB_READY,
    output logic                  REQA_DONE,
    output logic                  REQB_DONE,
    output logic [DATA_WIDTH-1:0] REQ_RDATA,
    output logic [ADDR_WIDTH-1:0] AMCI_WADDR,
    output logic [DATA_WIDTH-1:0] AMCI_WDATA,
    output logic                  AMCI_WRITE,
    input  logic                  AMCI_WIDLE,
    output logic [ADDR_WIDTH-1:0] AMCI_RADDR,
    output logic                  AMCI_READ,
    input  logic [DATA_WIDTH-1:0] AMCI_RDATA,
    input  logic                  AMCI_RIDLE,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR,
    output logic [1:0]            DBG_STATE
);

    // Handshake: a requester raises VALID with RNW/ADDR/WDATA stable and holds them until it
    // sees its one-cycle READY; the request is captured at the edge that moves IDLE -> ISSUE,
    // so VALID may drop freely once READY is seen. DONE pulses once when the access completes.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            grant_b_q;   // owner of the current/last grant; 1 = B
    logic            rnw_q;
    logic            done_a_q, done_b_q;
    logic            err_q;
    logic [CW-1:0]   wait_cnt_q;
    logic            win_b;
    logic            grant_en;
    logic            done_en;
    logic            idle_sel;

    // Contended: the requester not granted last wins; otherwise the lone requester wins.
    assign win_b    = REQB_VALID && (!REQA_VALID || !grant_b_q);
    assign idle_sel = rnw_q ? AMCI_RIDLE : AMCI_WIDLE;

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        done_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQA_VALID || REQB_VALID) begin
                    grant_en = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            // Downstream idle is low combinationally during the start pulse, so it is ignored here.
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (idle_sel) begin
                    done_en = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            grant_b_q  <= 1'b1;
            rnw_q      <= 1'b0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            REQ_RDATA  <= '0;
            AMCI_WADDR <= '0;
            AMCI_WDATA <= '0;
            AMCI_RADDR <= '0;
        end else begin
            state_q  <= state_d;
            done_a_q <= done_en && !grant_b_q;
            done_b_q <= done_en && grant_b_q;
            if (grant_en) begin
                grant_b_q <= win_b;
                rnw_q     <= win_b ? REQB_RNW : REQA_RNW;
                if (win_b ? REQB_RNW : REQA_RNW) begin
                    AMCI_RADDR <= win_b ? REQB_ADDR : REQA_ADDR;
                end else begin
                    AMCI_WADDR <= win_b ? REQB_ADDR : REQA_ADDR;
                    AMCI_WDATA <= win_b ? REQB_WDATA : REQA_WDATA;
                end
            end
            if (done_en && rnw_q) begin
                REQ_RDATA <= AMCI_RDATA;
            end
            // Counter reaches the limit at the edge closing the last allowed WAIT cycle.
            if (state_q == S_ISSUE) begin
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT && wait_cnt_q != CNT_MAX) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
                if (wait_cnt_q == CNT_LAST) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign REQA_READY  = (state_q == S_ISSUE) && !grant_b_q;
    assign REQB_READY  = (state_q == S_ISSUE) && grant_b_q;
    assign AMCI_WRITE  = (state_q == S_ISSUE) && !rnw_q;
    assign AMCI_READ   = (state_q == S_ISSUE) && rnw_q;
    assign REQA_DONE   = done_a_q;
    assign REQB_DONE   = done_b_q;
    assign BUSY        = (state_q != S_IDLE);
    assign TIMEOUT_ERR = err_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_amci_arbiter.sv
// Directed bench for amci_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_amci_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          REQA_VALID, REQA_RNW, REQB_VALID, REQB_RNW;
  logic [AW-1:0] REQA_ADDR, REQB_ADDR;
  logic [DW-1:0] REQA_WDATA, REQB_WDATA;
  logic          REQA_READY, REQB_READY, REQA_DONE, REQB_DONE;
  logic [DW-1:0] REQ_RDATA;
  logic [AW-1:0] AMCI_WADDR, AMCI_RADDR;
  logic [DW-1:0] AMCI_WDATA, AMCI_RDATA;
  logic          AMCI_WRITE, AMCI_READ, AMCI_WIDLE, AMCI_RIDLE;
  logic          BUSY, TIMEOUT_ERR;
  logic [1:0]    DBG_STATE;

  // {A_READY, B_READY, A_DONE, B_DONE, WRITE, READ, BUSY}
  logic [6:0]    flags;
  assign flags = {REQA_READY, REQB_READY, REQA_DONE, REQB_DONE, AMCI_WRITE, AMCI_READ, BUSY};

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  amci_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQA_VALID(REQA_VALID), .REQA_RNW(REQA_RNW), .REQA_ADDR(REQA_ADDR), .REQA_WDATA(REQA_WDATA),
    .REQB_VALID(REQB_VALID), .REQB_RNW(REQB_RNW), .REQB_ADDR(REQB_ADDR), .REQB_WDATA(REQB_WDATA),
    .REQA_READY(REQA_READY), .REQB_READY(REQB_READY), .REQA_DONE(REQA_DONE), .REQB_DONE(REQB_DONE),
    .REQ_RDATA(REQ_RDATA), .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
    .AMCI_WIDLE(AMCI_WIDLE), .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA),
    .AMCI_RIDLE(AMCI_RIDLE), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .DBG_STATE(DBG_STATE)
  );

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000000) begin n_errors++; $display("FAIL rst_flags got %b exp 0000000", flags); end
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b exp 0", TIMEOUT_ERR); end
    n_checks++;
    if (DBG_STATE !== 2'd0) begin n_errors++; $display("FAIL rst_state got %0d exp 0", DBG_STATE); end
    n_checks++;
    if ({AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, REQ_RDATA} !== '0) begin
      n_errors++; $display("FAIL rst_regs got %h %h %h %h exp 0", AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, REQ_RDATA);
    end
    RESET = 1'b0;
  endtask

  task automatic test_write_a();
    REQA_VALID = 1'b1; REQA_RNW = 1'b0; REQA_ADDR = 32'h10; REQA_WDATA = 32'hDEADBEEF;
    AMCI_WIDLE = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b1000101) begin n_errors++; $display("FAIL wr_issue got %b exp 1000101", flags); end
    n_checks++;
    if (AMCI_WADDR !== 32'h10 || AMCI_WDATA !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL wr_addr got %h/%h exp 00000010/deadbeef", AMCI_WADDR, AMCI_WDATA);
    end
    REQA_VALID = 1'b0; AMCI_WIDLE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (flags !== 7'b0000001) begin n_errors++; $display("FAIL wr_wait%0d got %b exp 0000001", i, flags); end
      n_checks++;
      if (AMCI_WADDR !== 32'h10 || AMCI_WDATA !== 32'hDEADBEEF) begin
        n_errors++; $display("FAIL wr_stable%0d got %h/%h", i, AMCI_WADDR, AMCI_WDATA);
      end
      if (i == 4) AMCI_WIDLE = 1'b1;
    end
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0010000) begin n_errors++; $display("FAIL wr_done got %b exp 0010000", flags); end
    n_checks++;
    if (REQ_RDATA !== 32'h0 || TIMEOUT_ERR !== 1'b0) begin
      n_errors++; $display("FAIL wr_side got rdata %h err %b exp 0/0", REQ_RDATA, TIMEOUT_ERR);
    end
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000000) begin n_errors++; $display("FAIL wr_after got %b exp 0000000", flags); end
  endtask

  task automatic test_read_b();
    REQB_VALID = 1'b1; REQB_RNW = 1'b1; REQB_ADDR = 32'h20; REQB_WDATA = 32'h55;
    AMCI_RDATA = 32'hBAD0BAD0; AMCI_RIDLE = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0100011) begin n_errors++; $display("FAIL rd_issue got %b exp 0100011", flags); end
    n_checks++;
    if (AMCI_RADDR !== 32'h20) begin n_errors++; $display("FAIL rd_addr got %h exp 00000020", AMCI_RADDR); end
    // RIDLE stays high through ISSUE: completion must wait for the first WAIT edge
    REQB_VALID = 1'b0; AMCI_RDATA = 32'h12345678;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000001) begin n_errors++; $display("FAIL rd_wait got %b exp 0000001", flags); end
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0001000) begin n_errors++; $display("FAIL rd_done got %b exp 0001000", flags); end
    n_checks++;
    if (REQ_RDATA !== 32'h12345678) begin n_errors++; $display("FAIL rd_data got %h exp 12345678", REQ_RDATA); end
    AMCI_RDATA = 32'hFFFF0000;
    REQA_VALID = 1'b1; REQA_RNW = 1'b0; REQA_ADDR = 32'h30; REQA_WDATA = 32'hCAFEF00D;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b1000101) begin n_errors++; $display("FAIL rdwr_issue got %b exp 1000101", flags); end
    n_checks++;
    if (AMCI_WADDR !== 32'h30) begin n_errors++; $display("FAIL rdwr_addr got %h exp 00000030", AMCI_WADDR); end
    REQA_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0010000) begin n_errors++; $display("FAIL rdwr_done got %b exp 0010000", flags); end
    n_checks++;
    if (REQ_RDATA !== 32'h12345678) begin n_errors++; $display("FAIL rdwr_hold got %h exp 12345678", REQ_RDATA); end
  endtask

  task automatic test_round_robin();
    logic a_turn;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    REQA_VALID = 1'b1; REQA_RNW = 1'b0; REQA_ADDR = 32'h100; REQA_WDATA = 32'hA0A0A0A0;
    REQB_VALID = 1'b1; REQB_RNW = 1'b0; REQB_ADDR = 32'h200; REQB_WDATA = 32'hB0B0B0B0;
    AMCI_WIDLE = 1'b1;
    for (int t = 0; t < 4; t++) begin
      a_turn = (t % 2 == 0);
      @(negedge CLK);
      n_checks++;
      if (flags !== (a_turn ? 7'b1000101 : 7'b0100101)) begin
        n_errors++; $display("FAIL rr_issue%0d got %b exp %b", t, flags, a_turn ? 7'b1000101 : 7'b0100101);
      end
      n_checks++;
      if (AMCI_WADDR !== (a_turn ? 32'h100 : 32'h200)) begin
        n_errors++; $display("FAIL rr_addr%0d got %h exp %h", t, AMCI_WADDR, a_turn ? 32'h100 : 32'h200);
      end
      AMCI_WIDLE = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (flags !== 7'b0000001) begin n_errors++; $display("FAIL rr_wait%0d got %b exp 0000001", t, flags); end
      AMCI_WIDLE = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (flags !== (a_turn ? 7'b0010000 : 7'b0001000)) begin
        n_errors++; $display("FAIL rr_done%0d got %b exp %b", t, flags, a_turn ? 7'b0010000 : 7'b0001000);
      end
    end
    REQA_VALID = 1'b0; REQB_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    REQA_VALID = 1'b1; REQA_RNW = 1'b0; REQA_ADDR = 32'h50; REQA_WDATA = 32'h5;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b1000101) begin n_errors++; $display("FAIL to_issue got %b exp 1000101", flags); end
    REQA_VALID = 1'b0; AMCI_WIDLE = 1'b0;
    for (int w = 1; w <= 20; w++) begin
      @(negedge CLK);
      n_checks++;
      if (flags !== 7'b0000001) begin n_errors++; $display("FAIL to_wait%0d got %b exp 0000001", w, flags); end
      n_checks++;
      if (TIMEOUT_ERR !== (w >= 17)) begin
        n_errors++; $display("FAIL to_err%0d got %b exp %b", w, TIMEOUT_ERR, (w >= 17));
      end
      if (w == 20) AMCI_WIDLE = 1'b1;
    end
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0010000) begin n_errors++; $display("FAIL to_done got %b exp 0010000", flags); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1) begin n_errors++; $display("FAIL to_sticky got %b exp 1", TIMEOUT_ERR); end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) begin n_errors++; $display("FAIL to_clear got %b exp 0", TIMEOUT_ERR); end
  endtask

  task automatic test_reset_in_wait();
    REQA_VALID = 1'b1; REQA_RNW = 1'b1; REQA_ADDR = 32'h60;
    AMCI_RIDLE = 1'b1; AMCI_RDATA = 32'h77777777;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b1000011) begin n_errors++; $display("FAIL rw_issue got %b exp 1000011", flags); end
    n_checks++;
    if (AMCI_RADDR !== 32'h60) begin n_errors++; $display("FAIL rw_addr got %h exp 00000060", AMCI_RADDR); end
    REQA_VALID = 1'b0; AMCI_RIDLE = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000001) begin n_errors++; $display("FAIL rw_wait got %b exp 0000001", flags); end
    RESET = 1'b1; AMCI_RIDLE = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000000 || TIMEOUT_ERR !== 1'b0) begin
      n_errors++; $display("FAIL rw_rst got %b err %b exp 0000000 err 0", flags, TIMEOUT_ERR);
    end
    n_checks++;
    if ({REQ_RDATA, AMCI_RADDR, DBG_STATE} !== '0) begin
      n_errors++; $display("FAIL rw_rst_regs got %h %h %0d exp 0", REQ_RDATA, AMCI_RADDR, DBG_STATE);
    end
    RESET = 1'b0;
    REQA_VALID = 1'b1; REQA_RNW = 1'b0; REQA_ADDR = 32'h70; REQA_WDATA = 32'h70707070;
    AMCI_WIDLE = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b1000101) begin n_errors++; $display("FAIL rw_regrant got %b exp 1000101", flags); end
    n_checks++;
    if (AMCI_WADDR !== 32'h70) begin n_errors++; $display("FAIL rw_waddr got %h exp 00000070", AMCI_WADDR); end
    REQA_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0000001) begin n_errors++; $display("FAIL rw_wait2 got %b exp 0000001", flags); end
    @(negedge CLK);
    n_checks++;
    if (flags !== 7'b0010000) begin n_errors++; $display("FAIL rw_done got %b exp 0010000", flags); end
  endtask

  initial begin
    RESET = 1'b1;
    REQA_VALID = 1'b0; REQA_RNW = 1'b0; REQA_ADDR = '0; REQA_WDATA = '0;
    REQB_VALID = 1'b0; REQB_RNW = 1'b0; REQB_ADDR = '0; REQB_WDATA = '0;
    AMCI_WIDLE = 1'b1; AMCI_RIDLE = 1'b1; AMCI_RDATA = '0;
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/amci_arbiter.md
AMCI_ARBITER -- requirements
Module: amci_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: WAIT-state cycle limit before TIMEOUT_ERR sets.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  clock; all logic on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 REQA_VALID / REQB_VALID  in  1  each: requester has a transaction pending; held until its READY.
REQ-008 REQA_RNW / REQB_RNW  in  1  each: 1 = read, 0 = write.
REQ-009 REQA_ADDR / REQB_ADDR  in  ADDR_WIDTH  each: transaction address.
REQ-010 REQA_WDATA / REQB_WDATA  in  DATA_WIDTH  each: write data; ignored for reads.
REQ-011 REQA_READY / REQB_READY  out  1  each: one-cycle pulse, request accepted.
REQ-012 REQA_DONE / REQB_DONE  out  1  each: one-cycle pulse, transaction complete.
REQ-013 REQ_RDATA  out  DATA_WIDTH  read data of the most recent completed read.
REQ-014 AMCI_WADDR, AMCI_WDATA  out  ADDR_WIDTH, DATA_WIDTH  to the downstream AXI no-burst master.
REQ-015 AMCI_WRITE  out  1  one-cycle write start pulse.
REQ-016 AMCI_WIDLE  in  1  downstream write engine idle.
REQ-017 AMCI_RADDR  out  ADDR_WIDTH;  AMCI_READ  out  1  one-cycle read start pulse.
REQ-018 AMCI_RDATA  in  DATA_WIDTH;  AMCI_RIDLE  in  1  downstream read engine idle.
REQ-019 BUSY  out  1  high in any state other than IDLE.
REQ-020 TIMEOUT_ERR  out  1  sticky flag, WAIT exceeded TIMEOUT_CYCLES.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-022 IDLE: at an edge with any VALID high, the block SHALL latch the grant, address, data and RNW of the winner and enter ISSUE; otherwise it stays in IDLE.
REQ-023 Arbitration SHALL be round-robin: both VALID high -> grant the requester not granted last; one VALID high -> grant it.
REQ-024 The last-grant register SHALL reset to B, so A wins the first contended cycle.
REQ-025 ISSUE (exactly one cycle): drive AMCI_WRITE=1 (RNW=0) or AMCI_READ=1 (RNW=1), and the winner's READY=1; then enter WAIT.
REQ-026 Latency: VALID sampled at edge N -> READY and AMCI_WRITE/READ high in cycle N..N+1, no earlier.
REQ-027 AMCI_WADDR, AMCI_WDATA and AMCI_RADDR SHALL be registered and stable from ISSUE through the end of WAIT.
REQ-028 WAIT: at the first edge where the selected idle input (AMCI_WIDLE for writes, AMCI_RIDLE for reads) is 1, the block SHALL pulse the winner's DONE for one cycle and enter IDLE.
REQ-029 For reads, that same edge SHALL capture AMCI_RDATA into REQ_RDATA; REQ_RDATA holds until the next read completes; writes leave it unchanged.
REQ-030 The idle input SHALL NOT be sampled during ISSUE, because the downstream idle is combinationally low while the start pulse is high.
REQ-031 A new grant SHALL NOT occur in the DONE cycle; the earliest re-grant is the edge after DONE, giving at most 1 transaction in flight.
REQ-032 WAIT counter: increments each WAIT cycle, clears on entry to WAIT, saturates at TIMEOUT_CYCLES.
REQ-033 When the counter reaches TIMEOUT_CYCLES, TIMEOUT_ERR SHALL set and stay set until RESET; the FSM keeps waiting and never aborts.
REQ-034 VALID dropping after grant SHALL NOT affect the transaction in flight.

Reset
REQ-035 RESET high at an edge SHALL force: FSM to IDLE, last grant to B, counter to 0, and all of READY, DONE, AMCI_WRITE, AMCI_READ, BUSY, TIMEOUT_ERR to 0.
REQ-036 REQ_RDATA and AMCI address/data SHALL reset to 0.
REQ-037 RESET mid-transaction SHALL abandon it with no DONE; the integrator drives the downstream master's active-low reset from the inverse of RESET.

Verification
REQ-038 A only, write 0x10/0xDEADBEEF; model idle low 5 cycles -> one AMCI_WRITE pulse, AMCI_WADDR=0x10, REQA_READY with it, REQA_DONE 1 cycle after WIDLE returns.
REQ-039 B read 0x20, model returns 0x12345678 -> REQ_RDATA=0x12345678 with REQB_DONE; the following write leaves REQ_RDATA unchanged.
REQ-040 A and B both VALID continuously for 4 transactions -> grant order A,B,A,B; never two in flight.
REQ-041 TIMEOUT_CYCLES=16, idle held low 20 cycles -> TIMEOUT_ERR rises on the 16th WAIT cycle, DONE follows idle; flag persists until RESET.
REQ-042 RESET asserted in WAIT -> next cycle all outputs 0, no DONE; a subsequent A request is granted normally.
